// File: rtl/mlp_pkg.sv
// Shared constants and the sequencer state type for the drowsiness-detector
// MLP (10 inputs, 5 hidden neurons, 3 output neurons).
package mlp_pkg;

  localparam int N_IN          = 10;
  localparam int N_HID         = 5;
  localparam int N_OUT         = 3;
  localparam int DW            = 10;
  localparam int ACC_W         = 24;

  localparam int HID_BASE      = 0;
  localparam int OUT_BASE      = 50;
  localparam int N_WEIGHTS     = 65;
  localparam int INFER_LATENCY = 75;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_HID_MAC,
    S_HID_ACT,
    S_OUT_MAC,
    S_OUT_ACT,
    S_FINISH
  } state_t;

endpackage

// File: rtl/mlp_mac.sv
// Signed multiply-accumulate unit shared by every neuron.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : clear accumulator (wins over en_i)
//   en_i         : add a_i * b_i to the accumulator
//   a_i          : unsigned operand (zero-extended)
//   b_i          : signed operand
//   acc_o        : signed accumulator
module mlp_mac
  import mlp_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [DW-1:0]           a_i,
  input  logic signed [DW-1:0]    b_i,
  output logic signed [ACC_W-1:0] acc_o
);

  localparam int PW = 2 * DW + 1;

  logic signed [PW-1:0]    a_ext;
  logic signed [PW-1:0]    b_ext;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_q;

  // Both operands are widened to the product width first so the multiply
  // is a plain signed one with no context-dependent extension.
  assign a_ext = {{(PW - DW){1'b0}}, a_i};
  assign b_ext = {{(PW - DW){b_i[DW-1]}}, b_i};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + {{(ACC_W - PW){prod[PW-1]}}, prod};
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mlp_sequencer.sv
// MLP controller: owns the 65-entry weight store, loads it over a
// valid/ready port, and schedules one shared MAC across 5 hidden and
// 3 output neurons (one product per cycle, 75-cycle inference).
// Ports:
//   Clock, Rst        : clock, synchronous active-high reset
//   wl_valid/wl_data  : weight-load word (signed), accepted when wl_ready
//   wl_ready          : store not yet full and sequencer idle
//   wl_restart        : in IDLE, discard loaded weights and restart loading
//   weights_valid     : all 65 weights loaded
//   start             : begin one inference (needs weights_valid)
//   inVal             : 10 unsigned features, feature i at [i*10 +: 10]
//   busy              : inference in progress
//   done              : one-cycle pulse in the result-update cycle
//   hidOut            : hidden activations of last inference (bit h)
//   outClass          : output activations of last inference (bit o)
module mlp_sequencer
  import mlp_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Rst,
  input  logic                 wl_valid,
  input  logic [DW-1:0]        wl_data,
  output logic                 wl_ready,
  input  logic                 wl_restart,
  output logic                 weights_valid,
  input  logic                 start,
  input  logic [N_IN*DW-1:0]   inVal,
  output logic                 busy,
  output logic                 done,
  output logic [N_HID-1:0]     hidOut,
  output logic [N_OUT-1:0]     outClass
);

  state_t state_q, state_d;

  logic [DW-1:0]    wmem_q [N_WEIGHTS];
  logic [6:0]       ptr_q;
  logic             wvalid_q;
  logic             accept;
  logic             restart_ok;

  logic [DW-1:0]    inval_q [N_IN];

  logic [2:0]       h_q, h_d;
  logic [3:0]       i_q, i_d;
  logic [1:0]       o_q, o_d;
  logic [N_HID-1:0] shid_q, shid_d;
  logic [N_OUT-1:0] sout_q, sout_d;
  logic [N_HID-1:0] hid_out_q, hid_out_d;
  logic [N_OUT-1:0] cls_q, cls_d;

  logic                    mac_clr;
  logic                    mac_en;
  logic [DW-1:0]           mac_a;
  logic signed [DW-1:0]    mac_b;
  logic signed [ACC_W-1:0] mac_acc;
  logic [6:0]              addr;
  logic                    acc_pos;

  // ---------------- weight loading ----------------
  assign wl_ready   = !wvalid_q && (state_q == S_IDLE);
  assign restart_ok = wl_restart && (state_q == S_IDLE);
  assign accept     = wl_valid && wl_ready && !wl_restart;

  always_ff @(posedge Clock) begin
    if (Rst || restart_ok) begin
      ptr_q    <= '0;
      wvalid_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= ptr_q + 7'd1;
      if (ptr_q == 7'(N_WEIGHTS - 1)) begin
        wvalid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (accept && !Rst) begin
      wmem_q[ptr_q] <= wl_data;
    end
  end

  // ---------------- feature capture ----------------
  always_ff @(posedge Clock) begin
    if (state_q == S_LATCH) begin
      for (int unsigned k = 0; k < N_IN; k++) begin
        inval_q[k] <= inVal[k*DW +: DW];
      end
    end
  end

  // ---------------- shared MAC ----------------
  mlp_mac u_mac (
    .clk_i (Clock),
    .rst_i (Rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (mac_a),
    .b_i   (mac_b),
    .acc_o (mac_acc)
  );

  // Strictly positive: sign clear and not zero.
  assign acc_pos = !mac_acc[ACC_W-1] && (mac_acc != '0);

  // ---------------- sequencer ----------------
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      h_q       <= '0;
      i_q       <= '0;
      o_q       <= '0;
      shid_q    <= '0;
      sout_q    <= '0;
      hid_out_q <= '0;
      cls_q     <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      i_q       <= i_d;
      o_q       <= o_d;
      shid_q    <= shid_d;
      sout_q    <= sout_d;
      hid_out_q <= hid_out_d;
      cls_q     <= cls_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    i_d       = i_q;
    o_d       = o_q;
    shid_d    = shid_q;
    sout_d    = sout_q;
    hid_out_d = hid_out_q;
    cls_d     = cls_q;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    mac_a     = '0;
    addr      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start && wvalid_q && !wl_restart) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        mac_clr = 1'b1;
        h_d     = '0;
        i_d     = '0;
        o_d     = '0;
        state_d = S_HID_MAC;
      end
      S_HID_MAC: begin
        mac_en = 1'b1;
        mac_a  = inval_q[i_q];
        addr   = 7'(HID_BASE) + 7'(h_q) * 7'(N_IN) + 7'(i_q);
        if (i_q == 4'(N_IN - 1)) begin
          i_d     = '0;
          state_d = S_HID_ACT;
        end else begin
          i_d = i_q + 4'd1;
        end
      end
      S_HID_ACT: begin
        shid_d[h_q] = acc_pos;
        mac_clr     = 1'b1;
        if (h_q == 3'(N_HID - 1)) begin
          h_d     = '0;
          state_d = S_OUT_MAC;
        end else begin
          h_d     = h_q + 3'd1;
          state_d = S_HID_MAC;
        end
      end
      S_OUT_MAC: begin
        // Hidden activation is 0/1, so multiplying by it gates the weight.
        mac_en = 1'b1;
        mac_a  = {{(DW - 1){1'b0}}, shid_q[h_q]};
        addr   = 7'(OUT_BASE) + 7'(o_q) * 7'(N_HID) + 7'(h_q);
        if (h_q == 3'(N_HID - 1)) begin
          h_d     = '0;
          state_d = S_OUT_ACT;
        end else begin
          h_d = h_q + 3'd1;
        end
      end
      S_OUT_ACT: begin
        sout_d[o_q] = acc_pos;
        mac_clr     = 1'b1;
        if (o_q == 2'(N_OUT - 1)) begin
          o_d     = '0;
          state_d = S_FINISH;
        end else begin
          o_d     = o_q + 2'd1;
          state_d = S_OUT_MAC;
        end
      end
      S_FINISH: begin
        hid_out_d = shid_q;
        cls_d     = sout_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mac_b         = wmem_q[addr];
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FINISH);
  assign weights_valid = wvalid_q;
  assign hidOut        = hid_out_q;
  assign outClass      = cls_q;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Self-checking bench for mlp_sequencer: random weights/features checked
// against a plain-arithmetic MLP model, plus load, start-filter, reset and
// restart-priority scenarios.
module tb_mlp_sequencer;
  import mlp_pkg::*;

  logic                 Clock = 1'b0;
  logic                 Rst;
  logic                 wl_valid;
  logic [DW-1:0]        wl_data;
  logic                 wl_ready;
  logic                 wl_restart;
  logic                 weights_valid;
  logic                 start;
  logic [N_IN*DW-1:0]   inVal;
  logic                 busy;
  logic                 done;
  logic [N_HID-1:0]     hidOut;
  logic [N_OUT-1:0]     outClass;

  int n_cmp = 0;
  int n_err = 0;
  int w [N_WEIGHTS];
  int x [N_IN];

  always #5 Clock = ~Clock;

  mlp_sequencer dut (
    .Clock         (Clock),
    .Rst           (Rst),
    .wl_valid      (wl_valid),
    .wl_data       (wl_data),
    .wl_ready      (wl_ready),
    .wl_restart    (wl_restart),
    .weights_valid (weights_valid),
    .start         (start),
    .inVal         (inVal),
    .busy          (busy),
    .done          (done),
    .hidOut        (hidOut),
    .outClass      (outClass)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // Reference: hidden h fires if sum_i x[i]*w[h*10+i] > 0;
  // output o fires if sum of w[50+o*5+h] over firing hidden h is > 0.
  function automatic void model(output logic [N_HID-1:0] eh, output logic [N_OUT-1:0] eo);
    longint s;
    for (int h = 0; h < 5; h++) begin
      s = 0;
      for (int i = 0; i < 10; i++) s += longint'(x[i]) * longint'(w[h*10 + i]);
      eh[h] = (s > 0);
    end
    for (int o = 0; o < 3; o++) begin
      s = 0;
      for (int h = 0; h < 5; h++) if (eh[h]) s += longint'(w[50 + o*5 + h]);
      eo[o] = (s > 0);
    end
  endfunction

  task automatic rand_weights;
    for (int k = 0; k < N_WEIGHTS; k++) w[k] = int'($urandom_range(1023)) - 512;
  endtask

  task automatic rand_inputs;
    for (int i = 0; i < N_IN; i++) x[i] = int'($urandom_range(1023));
  endtask

  // Loads w[] with random bubbles on wl_valid.
  task automatic load_all(input string tag);
    int n = 0;
    int cyc = 0;
    while (n < N_WEIGHTS && cyc < 400) begin
      wl_valid = ($urandom_range(3) != 0);
      wl_data  = 10'(w[n]);
      if (wl_valid && wl_ready) n++;
      tick;
      cyc++;
    end
    wl_valid = 1'b0;
    chk({tag, "_load_count"}, n, N_WEIGHTS);
    chk({tag, "_wvalid"}, weights_valid, 1);
  endtask

  task automatic pulse_restart;
    wl_restart = 1'b1;
    tick;
    wl_restart = 1'b0;
  endtask

  // Runs one inference from x[]/w[]. rst_at>0 asserts Rst in that cycle.
  task automatic infer(input string tag, input bit extra_start, input int rst_at,
                       output int min_acc);
    logic [N_HID-1:0] eh;
    logic [N_OUT-1:0] eo;
    int done_cnt = 0;
    int done_at  = -1;
    int busy_cnt = 0;
    min_acc = 0;
    model(eh, eo);
    for (int i = 0; i < N_IN; i++) inVal[i*DW +: DW] = 10'(x[i]);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (busy) busy_cnt++;
      if (int'(dut.u_mac.acc_o) < min_acc) min_acc = int'(dut.u_mac.acc_o);
      // Features are captured by now; later changes must not matter.
      if (k >= 2) inVal = {$urandom, $urandom, $urandom, $urandom};
      start = (extra_start && k == 20);
      if (rst_at > 0 && k == rst_at) Rst = 1'b1;
      if (rst_at > 0 && k == rst_at + 1) begin
        Rst = 1'b0;
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_done"}, done, 0);
        chk({tag, "_rst_hid"}, hidOut, 0);
        chk({tag, "_rst_cls"}, outClass, 0);
        chk({tag, "_rst_wvalid"}, weights_valid, 0);
        chk({tag, "_rst_ready"}, wl_ready, 1);
      end
      tick;
    end
    start = 1'b0;
    if (rst_at > 0) begin
      chk({tag, "_done_count"}, done_cnt, 0);
    end else begin
      chk({tag, "_done_count"}, done_cnt, 1);
      chk({tag, "_done_latency"}, done_at, INFER_LATENCY);
      chk({tag, "_busy_cycles"}, busy_cnt, INFER_LATENCY);
      chk({tag, "_hidOut"}, hidOut, eh);
      chk({tag, "_outClass"}, outClass, eo);
    end
  endtask

  initial begin
    int min_acc;
    int acc_cnt;
    logic bad;
    Rst = 1'b1; wl_valid = 1'b0; wl_data = '0; wl_restart = 1'b0;
    start = 1'b0; inVal = '0;
    repeat (3) tick;
    Rst = 1'b0;
    chk("reset_ready", wl_ready, 1);
    chk("reset_wvalid", weights_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hid", hidOut, 0);
    chk("reset_cls", outClass, 0);

    // Start without weights is ignored.
    start = 1'b1;
    tick;
    start = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 80; k++) begin
      bad |= busy | done;
      tick;
    end
    chk("start_no_weights", bad, 0);

    // Basic weights, loaded as 66 back-to-back words.
    for (int k = 0; k < 50; k++) w[k] = 1;
    for (int h = 0; h < 5; h++) begin
      w[50 + h] = 1;
      w[55 + h] = -1;
      w[60 + h] = 0;
    end
    acc_cnt = 0;
    for (int k = 0; k < 66; k++) begin
      wl_valid = 1'b1;
      wl_data  = (k < 65) ? 10'(w[k]) : 10'(-300);
      if (wl_ready) acc_cnt++;
      tick;
      if (k == 63) chk("load_wvalid_early", weights_valid, 0);
      if (k == 64) begin
        chk("load_wvalid_65", weights_valid, 1);
        chk("load_ready_65", wl_ready, 0);
      end
    end
    wl_valid = 1'b0;
    chk("load_accepted", acc_cnt, 65);

    for (int i = 0; i < N_IN; i++) x[i] = 1;
    infer("basic", 1'b0, 0, min_acc);
    chk("basic_hid_const", hidOut, 5'b11111);
    chk("basic_cls_const", outClass, 3'b001);
    rand_inputs;
    infer("second_start", 1'b1, 0, min_acc);
    for (int i = 0; i < N_IN; i++) x[i] = 0;
    infer("zero_inputs", 1'b0, 0, min_acc);

    // Extreme values.
    pulse_restart;
    chk("restart_wvalid", weights_valid, 0);
    for (int k = 0; k < 50; k++) w[k] = -512;
    for (int k = 50; k < 65; k++) w[k] = 1;
    load_all("extreme");
    for (int i = 0; i < N_IN; i++) x[i] = 1023;
    infer("extreme", 1'b0, 0, min_acc);
    chk("extreme_min_acc", min_acc, -5237760);

    // Reset mid-inference.
    rand_inputs;
    infer("midreset", 1'b0, 30, min_acc);

    // Restart wins over simultaneous start.
    rand_weights;
    load_all("pre_restart");
    rand_inputs;
    wl_restart = 1'b1;
    start      = 1'b1;
    tick;
    wl_restart = 1'b0;
    start      = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bad |= busy | done;
      tick;
    end
    chk("restart_start_busy", bad, 0);
    chk("restart_start_wvalid", weights_valid, 0);
    rand_weights;
    load_all("reload");
    infer("reload", 1'b0, 0, min_acc);

    // Random rounds.
    for (int r = 0; r < 5; r++) begin
      pulse_restart;
      rand_weights;
      load_all($sformatf("rnd%0d", r));
      for (int t = 0; t < 3; t++) begin
        rand_inputs;
        infer($sformatf("rnd%0d_%0d", r, t), 1'b0, 0, min_acc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
